// File: rtl/prog_fetch_arb.sv
// prog_fetch_arb: arbitrates CPU fetches and debug/loader reads onto one
// program-memory read port with a fixed read latency.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   cpu_req_i/cpu_adr_i     : CPU fetch request level and address
//   cpu_ack_o/cpu_dat_o     : CPU one-cycle completion pulse and fetched word
//   dbg_req_i/dbg_adr_i     : debug read request level and address
//   dbg_ack_o/dbg_dat_o     : debug completion pulse and read word
//   prog_adr_o/prog_rd_o    : memory address and one-cycle read strobe
//   prog_dat_i              : memory data, valid RD_LAT cycles after the strobe
//   busy_o                  : high while a transaction is in flight
module prog_fetch_arb #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned MAX_CPU_RUN  = 4,
  parameter logic [12:0] RESET_VECTOR = 13'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic [12:0] cpu_adr_i,
  output logic        cpu_ack_o,
  output logic [13:0] cpu_dat_o,
  input  logic        dbg_req_i,
  input  logic [12:0] dbg_adr_i,
  output logic        dbg_ack_o,
  output logic [13:0] dbg_dat_o,
  output logic [12:0] prog_adr_o,
  output logic        prog_rd_o,
  input  logic [13:0] prog_dat_i,
  output logic        busy_o
);

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 14;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          win_dbg_q, win_dbg_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          rd_q, rd_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] cpu_dat_q, cpu_dat_d;
  logic [DW-1:0] dbg_dat_q, dbg_dat_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          dbg_win;

  // State and output registers; every output comes straight from here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      win_dbg_q <= 1'b0;
      adr_q     <= RESET_VECTOR;
      rd_q      <= 1'b0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      cpu_dat_q <= '0;
      dbg_dat_q <= '0;
      run_cnt_q <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_dbg_q <= win_dbg_d;
      adr_q     <= adr_d;
      rd_q      <= rd_d;
      cpu_ack_q <= cpu_ack_d;
      dbg_ack_q <= dbg_ack_d;
      cpu_dat_q <= cpu_dat_d;
      dbg_dat_q <= dbg_dat_d;
      run_cnt_q <= run_cnt_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    win_dbg_d = win_dbg_q;
    adr_d     = adr_q;
    rd_d      = 1'b0;
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
    cpu_dat_d = cpu_dat_q;
    dbg_dat_d = dbg_dat_q;
    run_cnt_d = run_cnt_q;
    wait_d    = wait_q;
    dbg_win   = 1'b0;

    case (state_q)
      IDLE: begin
        // CPU has priority until it has starved a waiting debug request
        // for MAX_CPU_RUN consecutive grants.
        dbg_win = dbg_req_i && (!cpu_req_i || (run_cnt_q == CW'(MAX_CPU_RUN)));
        if (!dbg_req_i) run_cnt_d = '0;
        if (cpu_req_i || dbg_req_i) begin
          state_d   = ISSUE;
          win_dbg_d = dbg_win;
          adr_d     = dbg_win ? dbg_adr_i : cpu_adr_i;
          rd_d      = 1'b1;
          if (dbg_win) begin
            run_cnt_d = '0;
          end else if (dbg_req_i && (run_cnt_q != CW'(MAX_CPU_RUN))) begin
            run_cnt_d = run_cnt_q + CW'(1);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = WW'(RD_LAT - 1);
      end
      WAIT: begin
        if (wait_q == WW'(0)) begin
          state_d = RESP;
          if (win_dbg_q) begin
            dbg_dat_d = prog_dat_i;
            dbg_ack_d = 1'b1;
          end else begin
            cpu_dat_d = prog_dat_i;
            cpu_ack_d = 1'b1;
          end
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign cpu_ack_o  = cpu_ack_q;
  assign cpu_dat_o  = cpu_dat_q;
  assign dbg_ack_o  = dbg_ack_q;
  assign dbg_dat_o  = dbg_dat_q;
  assign prog_adr_o = adr_q;
  assign prog_rd_o  = rd_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_prog_fetch_arb.sv
// Scoreboard bench for prog_fetch_arb: RD_LAT=2 main instance plus RD_LAT=1
// and RD_LAT=4 instances for the latency corners.
module tb_prog_fetch_arb;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // main instance
  logic        m_cpu_req, m_dbg_req, m_cpu_ack, m_dbg_ack, m_rd, m_busy;
  logic [12:0] m_cpu_adr, m_dbg_adr, m_padr;
  logic [13:0] m_cpu_dat, m_dbg_dat, m_pdat;
  // latency-corner instances share one debug request
  logic        l_dbg_req;
  logic [12:0] l_dbg_adr;
  logic        a_cpu_ack, a_dbg_ack, a_rd, a_busy, b_cpu_ack, b_dbg_ack, b_rd, b_busy;
  logic [12:0] a_padr, b_padr;
  logic [13:0] a_cpu_dat, a_dbg_dat, a_pdat, b_cpu_dat, b_dbg_dat, b_pdat;

  prog_fetch_arb #(.RD_LAT(2), .MAX_CPU_RUN(4), .RESET_VECTOR(13'd0)) u_main (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(m_cpu_req), .cpu_adr_i(m_cpu_adr), .cpu_ack_o(m_cpu_ack), .cpu_dat_o(m_cpu_dat),
    .dbg_req_i(m_dbg_req), .dbg_adr_i(m_dbg_adr), .dbg_ack_o(m_dbg_ack), .dbg_dat_o(m_dbg_dat),
    .prog_adr_o(m_padr), .prog_rd_o(m_rd), .prog_dat_i(m_pdat), .busy_o(m_busy));

  prog_fetch_arb #(.RD_LAT(1), .MAX_CPU_RUN(4), .RESET_VECTOR(13'd0)) u_lat1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(1'b0), .cpu_adr_i(13'h0), .cpu_ack_o(a_cpu_ack), .cpu_dat_o(a_cpu_dat),
    .dbg_req_i(l_dbg_req), .dbg_adr_i(l_dbg_adr), .dbg_ack_o(a_dbg_ack), .dbg_dat_o(a_dbg_dat),
    .prog_adr_o(a_padr), .prog_rd_o(a_rd), .prog_dat_i(a_pdat), .busy_o(a_busy));

  prog_fetch_arb #(.RD_LAT(4), .MAX_CPU_RUN(4), .RESET_VECTOR(13'd0)) u_lat4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(1'b0), .cpu_adr_i(13'h0), .cpu_ack_o(b_cpu_ack), .cpu_dat_o(b_cpu_dat),
    .dbg_req_i(l_dbg_req), .dbg_adr_i(l_dbg_adr), .dbg_ack_o(b_dbg_ack), .dbg_dat_o(b_dbg_dat),
    .prog_adr_o(b_padr), .prog_rd_o(b_rd), .prog_dat_i(b_pdat), .busy_o(b_busy));

  // memory contents; any word outside the valid window reads as junk
  function automatic logic [13:0] mem(input logic [12:0] a);
    return (a == 13'h0123) ? 14'h2A5C : ({1'b0, a} ^ 14'h2C33);
  endfunction

  logic [3:0] vp_m, vp_a, vp_b;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vp_m <= '0; vp_a <= '0; vp_b <= '0;
    end else begin
      vp_m <= {vp_m[2:0], m_rd};
      vp_a <= {vp_a[2:0], a_rd};
      vp_b <= {vp_b[2:0], b_rd};
    end
  end
  assign m_pdat = vp_m[1] ? mem(m_padr) : 14'h3AAA;
  assign a_pdat = vp_a[0] ? mem(a_padr) : 14'h3AAA;
  assign b_pdat = vp_b[3] ? mem(b_padr) : 14'h3AAA;

  // port ids: 0 main cpu, 1 main dbg, 2 lat1 dbg, 3 lat4 dbg
  typedef struct {
    int          port;
    logic [13:0] dat;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int port, input logic [13:0] dat, input int c);
    exp_t e;
    e.port = port; e.dat = dat; e.cyc = c;
    sb.push_back(e);
  endtask

  function automatic logic [13:0] dat_of(input int p);
    case (p)
      0:       return m_cpu_dat;
      1:       return m_dbg_dat;
      2:       return a_dbg_dat;
      default: return b_dbg_dat;
    endcase
  endfunction

  // monitor: every ack pops one expectation
  always @(negedge clk_i) begin : mon
    logic [3:0] acks;
    exp_t       e;
    acks = {b_dbg_ack, a_dbg_ack, m_dbg_ack, m_cpu_ack};
    if ((a_cpu_ack === 1'b1) || (b_cpu_ack === 1'b1)) begin
      checks++; errors++;
      $display("FAIL stray_cpu_ack: got 1 expected 0 (cycle %0d)", cyc);
    end
    for (int p = 0; p < 4; p++) begin
      if (acks[p] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack on port %0d expected none (cycle %0d)", p, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_port", 32'(p), 32'(e.port));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          check("ack_data", 32'(dat_of(p)), 32'(e.dat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  int c, d, e, f, g, h;

  initial begin
    rst_i = 1'b0;
    m_cpu_req = 1'b0; m_dbg_req = 1'b0; m_cpu_adr = '0; m_dbg_adr = '0;
    l_dbg_req = 1'b0; l_dbg_adr = '0;

    // reset asserted mid-cycle takes effect immediately
    #2 rst_i = 1'b1;
    #1;
    check("rst_adr",     32'(m_padr),    32'h0);
    check("rst_rd",      32'(m_rd),      32'h0);
    check("rst_cpu_ack", 32'(m_cpu_ack), 32'h0);
    check("rst_dbg_ack", 32'(m_dbg_ack), 32'h0);
    check("rst_cpu_dat", 32'(m_cpu_dat), 32'h0);
    check("rst_dbg_dat", 32'(m_dbg_dat), 32'h0);
    check("rst_busy",    32'(m_busy),    32'h0);
    tick(); tick();
    check("rst_busy_hold", 32'(m_busy), 32'h0);

    // single CPU read, decision on the first edge after release
    tick(); c = cyc;
    rst_i = 1'b0; m_cpu_req = 1'b1; m_cpu_adr = 13'h0123;
    push(0, 14'h2A5C, c + 4);
    tick();
    check("issue_rd",   32'(m_rd),   32'h1);
    check("issue_adr",  32'(m_padr), 32'h0123);
    check("issue_busy", 32'(m_busy), 32'h1);
    m_cpu_req = 1'b0; m_cpu_adr = 13'h0777;
    tick();
    check("wait_rd",  32'(m_rd),   32'h0);
    check("wait_adr", 32'(m_padr), 32'h0123);
    wait_until(c + 5);
    check("idle_busy",     32'(m_busy),    32'h0);
    check("adr_hold",      32'(m_padr),    32'h0123);
    check("cpu_dat_hold",  32'(m_cpu_dat), 32'h2A5C);
    check("dbg_dat_clean", 32'(m_dbg_dat), 32'h0);

    // both held: CPU x4, DBG, CPU
    tick(); d = cyc;
    m_cpu_req = 1'b1; m_cpu_adr = 13'h00AA;
    m_dbg_req = 1'b1; m_dbg_adr = 13'h1555;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) push(1, mem(13'h1555), d + 4 + 5 * k);
      else        push(0, mem(13'h00AA), d + 4 + 5 * k);
    end
    wait_until(d + 26);
    m_cpu_req = 1'b0; m_dbg_req = 1'b0;
    wait_until(d + 30);

    // three CPU grants, debug dropped for one decision, then run restarts
    tick(); e = cyc;
    m_cpu_req = 1'b1; m_cpu_adr = 13'h00F0;
    m_dbg_req = 1'b1; m_dbg_adr = 13'h1ABC;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) push(1, mem(13'h1ABC), e + 4 + 5 * k);
      else        push(0, mem(13'h00F0), e + 4 + 5 * k);
    end
    wait_until(e + 11); m_dbg_req = 1'b0;
    wait_until(e + 16); m_dbg_req = 1'b1;
    wait_until(e + 41); m_cpu_req = 1'b0; m_dbg_req = 1'b0;
    wait_until(e + 45);
    check("dbg_dat_hold", 32'(m_dbg_dat), 32'(mem(13'h1ABC)));
    check("cpu_dat_last", 32'(m_cpu_dat), 32'(mem(13'h00F0)));

    // reset during WAIT of a debug read aborts it
    f = cyc;
    m_dbg_req = 1'b1; m_dbg_adr = 13'h0444;
    wait_until(f + 2);
    #2 rst_i = 1'b1;
    #1;
    check("abort_busy",    32'(m_busy),    32'h0);
    check("abort_rd",      32'(m_rd),      32'h0);
    check("abort_dbg_ack", 32'(m_dbg_ack), 32'h0);
    check("abort_dbg_dat", 32'(m_dbg_dat), 32'h0);
    check("abort_adr",     32'(m_padr),    32'h0);
    m_dbg_req = 1'b0;
    tick(); tick();
    check("abort_busy_hold", 32'(m_busy), 32'h0);
    tick(); g = cyc;
    rst_i = 1'b0; m_dbg_req = 1'b1; m_dbg_adr = 13'h0321;
    push(1, mem(13'h0321), g + 4);
    tick(); m_dbg_req = 1'b0;
    wait_until(g + 5);

    // lone debug read at the top address, RD_LAT = 1 and 4
    tick(); h = cyc;
    l_dbg_req = 1'b1; l_dbg_adr = 13'h1FFF;
    push(2, mem(13'h1FFF), h + 3);
    push(3, mem(13'h1FFF), h + 6);
    tick();
    check("lat1_adr", 32'(a_padr), 32'h1FFF);
    check("lat4_adr", 32'(b_padr), 32'h1FFF);
    check("lat1_rd",  32'(a_rd),   32'h1);
    check("lat4_rd",  32'(b_rd),   32'h1);
    l_dbg_req = 1'b0;
    wait_until(h + 8);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_fetch_arb.md
PROG_FETCH_ARB -- requirements
Module: prog_fetch_arb

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2, giving the cycles from the prog_rd_o pulse to valid prog_dat_i (legal 1..4).
REQ-002 The block SHALL have parameter MAX_CPU_RUN, default 4, giving the maximum consecutive CPU grants while debug waits (legal 1..15).
REQ-003 The block SHALL have parameter RESET_VECTOR [12:0], default 13'd0, giving the reset value of prog_adr_o.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have ports cpu_req_i (input, 1) and cpu_adr_i (input, 13): CPU fetch request level and address.
REQ-007 The block SHALL have ports cpu_ack_o (output, 1) and cpu_dat_o (output, 14): CPU one-cycle completion pulse and fetched word.
REQ-008 The block SHALL have ports dbg_req_i (input, 1) and dbg_adr_i (input, 13): debug/loader read request level and address.
REQ-009 The block SHALL have ports dbg_ack_o (output, 1) and dbg_dat_o (output, 14): debug completion pulse and read word.
REQ-010 The block SHALL have ports prog_adr_o (output, 13), prog_rd_o (output, 1) and prog_dat_i (input, 14): the program memory read port.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-013 IDLE: requests SHALL be sampled only here. With no request, stay in IDLE. With any request, latch the winner id and its address, then go to ISSUE.
REQ-014 ISSUE: prog_rd_o SHALL be 1 for exactly this cycle, prog_adr_o SHALL equal the latched address, then go to WAIT.
REQ-015 WAIT: the FSM SHALL stay for exactly RD_LAT cycles; at the final WAIT edge, capture prog_dat_i into the winner's dat register, then go to RESP.
REQ-016 RESP: the winner's ack SHALL be 1 for one cycle with its dat_o valid, then go to IDLE; the other ack SHALL stay 0.
REQ-017 Latency: ack SHALL assert RD_LAT+2 cycles after the IDLE decision cycle; a held request SHALL be re-served every RD_LAT+3 cycles.
REQ-018 Request and address changes outside IDLE SHALL be ignored; a req still high in the IDLE after RESP SHALL start a new read.
REQ-019 Arbitration: CPU SHALL win over debug, except that debug wins when dbg_req_i=1 and run_cnt==MAX_CPU_RUN.
REQ-020 run_cnt (4 bits) SHALL increment on a CPU grant while dbg_req_i=1, saturating at MAX_CPU_RUN.
REQ-021 run_cnt SHALL clear on a debug grant, and on any IDLE decision with dbg_req_i=0.
REQ-022 prog_adr_o SHALL be registered and hold the last issued address between transactions.
REQ-023 prog_rd_o SHALL be 0 outside ISSUE.
REQ-024 cpu_dat_o and dbg_dat_o SHALL each hold their last captured value until that port's next capture.
REQ-025 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-026 While rst_i=1, the block SHALL hold FSM=IDLE, prog_adr_o=RESET_VECTOR, prog_rd_o=0, both acks=0, both dat_o=0, run_cnt=0 and busy_o=0.
REQ-027 Reset asserted in ISSUE, WAIT or RESP SHALL abort the transaction immediately, with no ack, no capture and no replay.
REQ-028 After rst_i deasserts, the first IDLE decision SHALL occur on the next rising edge.

Verification
REQ-029 Reset: assert rst_i mid-cycle -> outputs reach REQ-026 values immediately; prog_adr_o=13'h0000.
REQ-030 Single CPU read, RD_LAT=2, cpu_adr_i=13'h0123, memory returns 14'h2A5C in cycle 3 -> prog_rd_o=1 with prog_adr_o=13'h0123 in cycle 1; cpu_ack_o=1 with cpu_dat_o=14'h2A5C in cycle 4; dbg_ack_o stays 0.
REQ-031 Both requests held continuously, MAX_CPU_RUN=4 -> grant sequence CPU,CPU,CPU,CPU,DBG,CPU,...; acks spaced 5 cycles apart.
REQ-032 Both requests held until 3 CPU grants, then dbg_req_i dropped for one IDLE decision and reasserted -> run_cnt clears; the next 4 grants go to CPU before debug is served.
REQ-033 rst_i pulsed during WAIT of a debug read -> no dbg_ack_o, dbg_dat_o=0, busy_o=0; a fresh request after release completes normally.
REQ-034 RD_LAT=1 and RD_LAT=4 with a lone debug request at 13'h1FFF -> ack at cycles 3 and 6 respectively, with prog_adr_o=13'h1FFF.
